fetch_icache: RTL and testbench
===============================

// Module: fetch_icache
// PURPOSE
//   Instruction fetch unit with a small direct-mapped instruction cache, one per core.
//   Consumes current_pc, the PC that the per-thread next-PC logic produces, during the core FETCH state.
//   On a cache hit, returns the instruction to the decoder. On a miss, issues a program-memory
//   read via the valid/ready memory-controller interface and fills the cache with the result.
// PARAMETERS
//   PROGRAM_MEM_ADDR_BITS  8   program memory address width
//   PROGRAM_MEM_DATA_BITS  16  instruction width
//   CACHE_ENTRIES          4   number of cache lines; power of two, >= 2; 1 instruction per line
// PORTS
//   clk               in   1       clock
//   reset             in   1       synchronous, active-high
//   core_state        in   3       core FSM state; 001=FETCH, 010=DECODE
//   current_pc        in   ADDR    PC to fetch; sampled on FETCH entry only
//   flush             in   1       invalidate all cache lines (kernel start / program reload)
//   mem_read_valid    out  1       program-memory read request
//   mem_read_address  out  ADDR    request address
//   mem_read_ready    in   1       read data valid this cycle
//   mem_read_data     in   DATA    returned instruction
//   fetcher_state     out  3       000=IDLE, 001=FETCHING, 010=FETCHED
//   instruction       out  DATA    fetched instruction; stable while FETCHED
// BEHAVIOUR
//   Reset:
//     - fetcher_state=IDLE, mem_read_valid=0, mem_read_address=0, instruction=0.
//     - All line valid bits=0. Tag/data arrays need no reset.
//   Indexing:
//     - idx=current_pc[IDX-1:0], where IDX=log2(CACHE_ENTRIES).
//     - tag=current_pc[ADDR-1:IDX].
//     - Hit = valid[idx] && tag_q[idx]==tag.
//   IDLE, core_state==FETCH:
//     - Hit: instruction<=data[idx]; state->FETCHED. One-cycle latency, no memory request.
//     - Miss: mem_read_valid<=1, mem_read_address<=current_pc; state->FETCHING.
//   IDLE, any other core_state: no action. mem_read_ready is ignored.
//   FETCHING:
//     - Hold mem_read_valid=1 and the latched address stable until mem_read_ready==1 is sampled.
//     - current_pc changes during this state are ignored.
//   FETCHING, mem_read_ready==1 (same edge):
//     - mem_read_valid<=0; instruction<=mem_read_data.
//     - Line idx of the latched address: data, tag written and valid set.
//     - state->FETCHED.
//     - Ready asserted in the same cycle valid first rises is legal. Ready is only sampled from
//       the cycle after entering FETCHING.
//   FETCHED:
//     - Hold instruction.
//     - core_state==DECODE -> IDLE; otherwise remain FETCHED.
//   Replacement: direct-mapped; a miss always overwrites line idx, even if it is valid.
//   flush:
//     - Clears all valid bits at the next edge, in any state.
//     - Does not abort an outstanding request; the data is still delivered to instruction.
//     - flush coincident with a fill: flush wins and the line stays invalid.
//     - flush coincident with an IDLE lookup: lookup uses the pre-flush array (hit allowed).
//   Reset during FETCHING:
//     - Next cycle mem_read_valid=0 and state=IDLE.
//     - A late mem_read_ready is ignored and no fill occurs.
//   mem_read_valid is only ever high in FETCHING. At most one outstanding request.
// TESTING
//   Cold miss:
//     - Stimulus: reset; FETCH with pc=0x03; ready after 2 cycles with data=0xA5C3.
//     - Response: valid=1 and address=0x03 until ready; instruction=0xA5C3; state=FETCHED.
//   Hit:
//     - Stimulus: after cold miss, DECODE, then FETCH pc=0x03 again.
//     - Response: FETCHED in 1 cycle; mem_read_valid stays 0; instruction=0xA5C3.
//   Alias eviction (4 entries):
//     - Stimulus: fill 0x01=0x1111, fill 0x05=0x5555, fetch 0x01.
//     - Response: miss, new request to 0x01; line 1 holds tag of 0x01 afterwards.
//   Flush:
//     - Stimulus: fill 0x02, pulse flush, fetch 0x02.
//     - Response: miss, request issued.
//     - Stimulus: flush on the fill edge.
//     - Response: instruction still delivered, next fetch misses.
//   Reset mid-fetch:
//     - Stimulus: reset while FETCHING, then ready=1 with data=0xFFFF.
//     - Response: state=IDLE, valid=0, instruction=0; a later fetch of that pc misses.
//   PC stability:
//     - Stimulus: change current_pc during FETCHING.
//     - Response: mem_read_address unchanged; fill goes to the originally latched index.

Source files
------------

// File: rtl/fetch_icache.sv
`default_nettype none
// ============================================================================
// Module   : fetch_icache
// Purpose  : Instruction fetch unit with a direct-mapped, one-word-per-line
//            instruction cache in front of a valid/ready program memory.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_icache #(
    parameter int PROGRAM_MEM_ADDR_BITS = 8,
    parameter int PROGRAM_MEM_DATA_BITS = 16,
    parameter int CACHE_ENTRIES         = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [2:0]                       core_state,
    input  logic [PROGRAM_MEM_ADDR_BITS-1:0] current_pc,
    input  logic                             flush,
    output logic                             mem_read_valid,
    output logic [PROGRAM_MEM_ADDR_BITS-1:0] mem_read_address,
    input  logic                             mem_read_ready,
    input  logic [PROGRAM_MEM_DATA_BITS-1:0] mem_read_data,
    output logic [2:0]                       fetcher_state,
    output logic [PROGRAM_MEM_DATA_BITS-1:0] instruction
);

    localparam int IDX_BITS = $clog2(CACHE_ENTRIES);
    localparam int TAG_BITS = PROGRAM_MEM_ADDR_BITS - IDX_BITS;

    localparam logic [2:0] CORE_FETCH  = 3'b001;
    localparam logic [2:0] CORE_DECODE = 3'b010;

    typedef enum logic [2:0] {
        S_IDLE     = 3'b000,
        S_FETCHING = 3'b001,
        S_FETCHED  = 3'b010
    } state_t;

    state_t                             state_q, state_d;
    logic                               mem_read_valid_q, mem_read_valid_d;
    logic [PROGRAM_MEM_ADDR_BITS-1:0]   mem_read_address_q, mem_read_address_d;
    logic [PROGRAM_MEM_DATA_BITS-1:0]   instruction_q, instruction_d;
    logic [CACHE_ENTRIES-1:0]           line_valid_q, line_valid_d;

    // Tag and data storage carry no reset; line_valid_q alone qualifies them.
    logic [TAG_BITS-1:0]                tag_q  [CACHE_ENTRIES];
    logic [PROGRAM_MEM_DATA_BITS-1:0]   data_q [CACHE_ENTRIES];

    logic [IDX_BITS-1:0]                lookup_idx;
    logic [TAG_BITS-1:0]                lookup_tag;
    logic                               lookup_hit;
    logic [IDX_BITS-1:0]                fill_idx;
    logic [TAG_BITS-1:0]                fill_tag;
    logic                               fill_en;

    assign lookup_idx = current_pc[IDX_BITS-1:0];
    assign lookup_tag = current_pc[PROGRAM_MEM_ADDR_BITS-1:IDX_BITS];
    assign lookup_hit = line_valid_q[lookup_idx] && (tag_q[lookup_idx] == lookup_tag);

    // The fill target comes from the latched request address, never current_pc.
    assign fill_idx = mem_read_address_q[IDX_BITS-1:0];
    assign fill_tag = mem_read_address_q[PROGRAM_MEM_ADDR_BITS-1:IDX_BITS];

    always_comb begin
        state_d            = state_q;
        mem_read_valid_d   = mem_read_valid_q;
        mem_read_address_d = mem_read_address_q;
        instruction_d      = instruction_q;
        line_valid_d       = line_valid_q;
        fill_en            = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (core_state == CORE_FETCH) begin
                    if (lookup_hit) begin
                        instruction_d = data_q[lookup_idx];
                        state_d       = S_FETCHED;
                    end else begin
                        mem_read_valid_d   = 1'b1;
                        mem_read_address_d = current_pc;
                        state_d            = S_FETCHING;
                    end
                end
            end
            S_FETCHING: begin
                if (mem_read_ready) begin
                    mem_read_valid_d       = 1'b0;
                    instruction_d          = mem_read_data;
                    fill_en                = 1'b1;
                    line_valid_d[fill_idx] = 1'b1;
                    state_d                = S_FETCHED;
                end
            end
            S_FETCHED: begin
                if (core_state == CORE_DECODE) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                mem_read_valid_d = 1'b0;
                state_d          = S_IDLE;
            end
        endcase

        // Flush overrides a coincident fill; lookups above saw the old array.
        if (flush) begin
            line_valid_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q            <= S_IDLE;
            mem_read_valid_q   <= 1'b0;
            mem_read_address_q <= '0;
            instruction_q      <= '0;
            line_valid_q       <= '0;
        end else begin
            state_q            <= state_d;
            mem_read_valid_q   <= mem_read_valid_d;
            mem_read_address_q <= mem_read_address_d;
            instruction_q      <= instruction_d;
            line_valid_q       <= line_valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (fill_en && !reset) begin
            tag_q[fill_idx]  <= fill_tag;
            data_q[fill_idx] <= mem_read_data;
        end
    end

    assign mem_read_valid   = mem_read_valid_q;
    assign mem_read_address = mem_read_address_q;
    assign fetcher_state    = state_q;
    assign instruction      = instruction_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_icache.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_icache
// Purpose  : Directed plus randomized check of fetch_icache against a
//            line-level cache model holding full PCs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_icache;

    localparam int ADDR    = 8;
    localparam int DATA    = 16;
    localparam int ENTRIES = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic [2:0]        core_state;
    logic [ADDR-1:0]   current_pc;
    logic              flush;
    logic              mem_read_valid;
    logic [ADDR-1:0]   mem_read_address;
    logic              mem_read_ready;
    logic [DATA-1:0]   mem_read_data;
    logic [2:0]        fetcher_state;
    logic [DATA-1:0]   instruction;

    int errors = 0;
    int checks = 0;

    // Reference model: each line remembers the full PC it caches.
    bit              m_valid [ENTRIES];
    logic [ADDR-1:0] m_pc    [ENTRIES];
    logic [DATA-1:0] m_data  [ENTRIES];

    fetch_icache #(
        .PROGRAM_MEM_ADDR_BITS(ADDR),
        .PROGRAM_MEM_DATA_BITS(DATA),
        .CACHE_ENTRIES        (ENTRIES)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .core_state      (core_state),
        .current_pc      (current_pc),
        .flush           (flush),
        .mem_read_valid  (mem_read_valid),
        .mem_read_address(mem_read_address),
        .mem_read_ready  (mem_read_ready),
        .mem_read_data   (mem_read_data),
        .fetcher_state   (fetcher_state),
        .instruction     (instruction)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < ENTRIES; i++) m_valid[i] = 1'b0;
    endtask

    task automatic do_fetch(input logic [ADDR-1:0] pc, input int delay, input logic [DATA-1:0] rdata,
                            input bit flush_lookup, input bit flush_fill);
        int              idx;
        bit              hit;
        int              hold;
        logic [DATA-1:0] exp_instr;
        logic [2:0]      cs;
        idx  = int'(pc) % ENTRIES;
        hit  = m_valid[idx] && (m_pc[idx] == pc);
        exp_instr  = m_data[idx];
        core_state = 3'b001;
        current_pc = pc;
        flush      = flush_lookup;
        tick();
        flush      = 1'b0;
        core_state = 3'b000;
        if (flush_lookup) model_clear();
        if (hit) begin
            check("hit_state", fetcher_state, 3'b010);
            check("hit_valid", mem_read_valid, 1'b0);
            check("hit_instr", instruction, exp_instr);
        end else begin
            check("miss_state", fetcher_state, 3'b001);
            check("miss_valid", mem_read_valid, 1'b1);
            check("miss_addr", mem_read_address, pc);
            for (int c = 0; c < delay; c++) begin
                current_pc = ADDR'($urandom);
                tick();
                check("hold_state", fetcher_state, 3'b001);
                check("hold_valid", mem_read_valid, 1'b1);
                check("hold_addr", mem_read_address, pc);
            end
            mem_read_ready = 1'b1;
            mem_read_data  = rdata;
            flush          = flush_fill;
            current_pc     = ADDR'($urandom);
            tick();
            mem_read_ready = 1'b0;
            flush          = 1'b0;
            mem_read_data  = DATA'($urandom);
            check("fill_state", fetcher_state, 3'b010);
            check("fill_valid", mem_read_valid, 1'b0);
            check("fill_instr", instruction, rdata);
            exp_instr   = rdata;
            m_valid[idx] = 1'b1;
            m_pc[idx]    = pc;
            m_data[idx]  = rdata;
            if (flush_fill) model_clear();
        end
        hold = $urandom_range(0, 2);
        for (int c = 0; c < hold; c++) begin
            cs = 3'($urandom_range(0, 7));
            if (cs == 3'b010) cs = 3'b001;
            core_state = cs;
            tick();
            check("fetched_state", fetcher_state, 3'b010);
            check("fetched_instr", instruction, exp_instr);
        end
        core_state = 3'b010;
        tick();
        core_state = 3'b000;
        check("decode_idle", fetcher_state, 3'b000);
        check("decode_valid", mem_read_valid, 1'b0);
    endtask

    initial begin
        reset          = 1'b1;
        core_state     = 3'b000;
        current_pc     = '0;
        flush          = 1'b0;
        mem_read_ready = 1'b0;
        mem_read_data  = '0;
        model_clear();
        for (int i = 0; i < ENTRIES; i++) begin
            m_pc[i]   = '0;
            m_data[i] = '0;
        end
        tick();
        tick();
        check("rst_state", fetcher_state, 3'b000);
        check("rst_valid", mem_read_valid, 1'b0);
        check("rst_addr", mem_read_address, 8'h00);
        check("rst_instr", instruction, 16'h0000);
        reset = 1'b0;

        // Cold miss then hit
        do_fetch(8'h03, 2, 16'hA5C3, 1'b0, 1'b0);
        do_fetch(8'h03, 0, 16'h0000, 1'b0, 1'b0);
        // Alias eviction: 0x01 and 0x05 share line 1
        do_fetch(8'h01, 1, 16'h1111, 1'b0, 1'b0);
        do_fetch(8'h05, 0, 16'h5555, 1'b0, 1'b0);
        do_fetch(8'h01, 1, 16'h1A1A, 1'b0, 1'b0);
        do_fetch(8'h01, 0, 16'h0000, 1'b0, 1'b0);
        do_fetch(8'h05, 0, 16'h5A5A, 1'b0, 1'b0);
        // Flush pulse in idle
        do_fetch(8'h02, 0, 16'h2222, 1'b0, 1'b0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        model_clear();
        do_fetch(8'h02, 1, 16'h2BBB, 1'b0, 1'b0);
        // Flush on the fill edge, then flush coincident with a hit lookup
        do_fetch(8'h06, 2, 16'h6666, 1'b0, 1'b1);
        do_fetch(8'h06, 0, 16'h6767, 1'b0, 1'b0);
        do_fetch(8'h06, 0, 16'h0000, 1'b1, 1'b0);
        do_fetch(8'h06, 0, 16'h6868, 1'b0, 1'b0);

        // Reset while FETCHING with a late ready
        flush = 1'b1;
        tick();
        flush = 1'b0;
        model_clear();
        core_state = 3'b001;
        current_pc = 8'h09;
        tick();
        check("rmf_fetching", fetcher_state, 3'b001);
        core_state     = 3'b000;
        reset          = 1'b1;
        mem_read_ready = 1'b1;
        mem_read_data  = 16'hFFFF;
        tick();
        reset = 1'b0;
        check("rmf_state", fetcher_state, 3'b000);
        check("rmf_valid", mem_read_valid, 1'b0);
        check("rmf_instr", instruction, 16'h0000);
        tick();
        mem_read_ready = 1'b0;
        check("rmf_late_state", fetcher_state, 3'b000);
        check("rmf_late_instr", instruction, 16'h0000);
        model_clear();
        do_fetch(8'h09, 0, 16'h9999, 1'b0, 1'b0);

        // Randomized traffic over a small PC window to force hits and aliasing
        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 7) == 0) begin
                mem_read_ready = 1'b1;
                mem_read_data  = DATA'($urandom);
                flush          = 1'($urandom_range(0, 1));
                tick();
                if (flush) model_clear();
                mem_read_ready = 1'b0;
                flush          = 1'b0;
                check("idle_noise_state", fetcher_state, 3'b000);
                check("idle_noise_valid", mem_read_valid, 1'b0);
            end
            do_fetch(ADDR'($urandom_range(0, 15)), $urandom_range(0, 3), DATA'($urandom),
                     $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
